// File: rtl/block_data_memory.sv
// Block-granular data memory serving cache line fills and write-backs.
// Access completes LATENCY edges after acceptance; BUSYWAIT stalls the requester.
// Optional per-byte write masking is enabled by defining DMEM_WRITE_MASK_EN.
module block_data_memory #(
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_WIDTH  = 28,
  parameter int DEPTH       = 64,
  parameter int LATENCY     = 5
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     MEM_READ,
  input  logic                     MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0]    MEM_ADDRESS,
  input  logic [8*BLOCK_BYTES-1:0] DATA_IN,
`ifdef DMEM_WRITE_MASK_EN
  input  logic [BLOCK_BYTES-1:0]   WRITE_MASK,
`endif
  output logic [8*BLOCK_BYTES-1:0] DATA_OUT,
  output logic                     BUSYWAIT
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BLK_W = 8 * BLOCK_BYTES;

  typedef enum logic [2:0] {INIT, IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_next;

  logic [BLK_W-1:0]       mem [DEPTH];
  logic [IDX_W-1:0]       ptr;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLK_W-1:0]       data_q;
  logic [BLOCK_BYTES-1:0] mask_q;
  logic [BLK_W-1:0]       wr_blk;
  logic [IDX_W-1:0]       idx;
  logic                   accept;
  logic                   in_range;
  logic                   finish;

  // A request is taken only when exactly one of read/write is asserted in IDLE
  assign accept   = (state == IDLE) && (MEM_READ ^ MEM_WRITE);
  // Out-of-range blocks read as zero and swallow writes
  assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH+1)'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];
  assign finish   = (cnt == '0);

`ifdef DMEM_WRITE_MASK_EN
  // Byte-enable mask captured together with the address and data
  always_ff @(posedge CLK) begin
    if (RESET)       mask_q <= '0;
    else if (accept) mask_q <= WRITE_MASK;
  end
`else
  // Without masking every write replaces the whole block
  always_comb mask_q = '1;
`endif

  // Merge latched data into the stored block byte by byte
  always_comb begin
    wr_blk = '0;
    for (int b = 0; b < BLOCK_BYTES; b++)
      wr_blk[8*b +: 8] = mask_q[b] ? data_q[8*b +: 8] : mem[idx][8*b +: 8];
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= INIT;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      INIT:        if (ptr == IDX_W'(DEPTH - 1)) state_next = IDLE;
      IDLE:        if (accept) state_next = MEM_READ ? READ : WRITE;
      READ, WRITE: if (finish) state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = INIT;
    endcase
  end

  // Stall output; combinational in IDLE so the requester stalls the same cycle
  always_comb begin
    BUSYWAIT = 1'b1;
    case (state)
      IDLE:    BUSYWAIT = MEM_READ ^ MEM_WRITE;
      DONE:    BUSYWAIT = 1'b0;
      default: BUSYWAIT = 1'b1;
    endcase
  end

  // Sweep pointer, latency counter, request latches and registered read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr      <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      DATA_OUT <= '0;
    end else begin
      if (state == INIT) ptr <= ptr + IDX_W'(1);
      if (accept) begin
        addr_q <= MEM_ADDRESS;
        data_q <= DATA_IN;
        cnt    <= CNT_W'(LATENCY - 1);
      end else if ((state == READ || state == WRITE) && !finish) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == READ && finish) DATA_OUT <= in_range ? mem[idx] : '0;
    end
  end

  // Storage: zeroed by the INIT sweep, updated when a WRITE completes
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == INIT)
        mem[ptr] <= '0;
      else if (state == WRITE && finish && in_range)
        mem[idx] <= wr_blk;
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory (default parameters: 16-byte blocks, depth 64, latency 5).
// Transaction-level model predicts BUSYWAIT/DATA_OUT each cycle; compared on negedge.
// Masking tests run only when DMEM_WRITE_MASK_EN is defined.
module tb_block_data_memory;
  localparam int LAT = 5;
  localparam int DEP = 64;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         MEM_READ = 1'b0;
  logic         MEM_WRITE = 1'b0;
  logic [27:0]  MEM_ADDRESS = '0;
  logic [127:0] DATA_IN = '0;
`ifdef DMEM_WRITE_MASK_EN
  logic [15:0]  WRITE_MASK = '0;
`endif
  logic [127:0] DATA_OUT;
  logic         BUSYWAIT;

  block_data_memory dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .DATA_IN(DATA_IN),
`ifdef DMEM_WRITE_MASK_EN
    .WRITE_MASK(WRITE_MASK),
`endif
    .DATA_OUT(DATA_OUT), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model: stored blocks plus the expected outputs for the current cycle
  logic [127:0] mdl [DEP];
  logic         exp_busy = 1'b1;
  logic [127:0] exp_dout = '0;
  logic         chk_en = 1'b0;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      vectors++;
      if (BUSYWAIT !== exp_busy || DATA_OUT !== exp_dout) begin
        miscompares++;
        $display("FAIL cycle@%0t busy got %b want %b, dout got %h want %h",
                 $time, BUSYWAIT, exp_busy, DATA_OUT, exp_dout);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // One reset edge followed by the DEPTH-cycle clearing sweep
  task automatic do_reset();
    chk_en    = 1'b0;
    RESET     = 1'b1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    step();
    RESET = 1'b0;
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    exp_dout = '0;
    exp_busy = 1'b1;
    chk_en   = 1'b1;
    repeat (DEP) step();
    exp_busy = 1'b0;
  endtask

  // Full access from IDLE; optionally disturbs address/data right after acceptance
  task automatic access(input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] d, input logic [15:0] m, input bit scramble);
    logic [15:0] mm;
    MEM_READ    = rd;
    MEM_WRITE   = wr;
    MEM_ADDRESS = a;
    DATA_IN     = d;
`ifdef DMEM_WRITE_MASK_EN
    WRITE_MASK  = m;
    mm = m;
`else
    mm = m | 16'hFFFF;  // full-block writes when masking is not built in
`endif
    exp_busy = 1'b1;
    step();
    for (int i = 0; i < LAT; i++) begin
      if (i == 0 && scramble) begin
        MEM_ADDRESS = a + 28'd2;
        DATA_IN     = ~d;
`ifdef DMEM_WRITE_MASK_EN
        WRITE_MASK  = ~m;
`endif
      end
      exp_busy = 1'b1;
      step();
    end
    if (rd) exp_dout = (a < DEP) ? mdl[a[5:0]] : '0;
    if (wr && a < DEP)
      for (int b = 0; b < 16; b++)
        if (mm[b]) mdl[a[5:0]][8*b +: 8] = d[8*b +: 8];
    exp_busy  = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    step();
  endtask

  localparam logic [127:0] D3  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2  = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [127:0] D70 = 128'h11111111_22222222_33333333_44444444;

  initial begin
    do_reset();

    access(1'b1, 1'b0, 28'd5, '0, '1, 1'b0);
    check("rd5_after_init", DATA_OUT, 128'h0);

    access(1'b0, 1'b1, 28'd3, D3, '1, 1'b0);
    access(1'b1, 1'b0, 28'd3, '0, '1, 1'b0);
    check("rd3", DATA_OUT, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    access(1'b1, 1'b0, 28'd70, '0, '1, 1'b0);
    check("rd70_oob", DATA_OUT, 128'h0);
    access(1'b0, 1'b1, 28'd70, D70, '1, 1'b0);
    access(1'b1, 1'b0, 28'd6, '0, '1, 1'b0);
    check("rd6_no_alias", DATA_OUT, 128'h0);

    // Both requests high: illegal, nothing accepted, no stall
    access(1'b1, 1'b0, 28'd3, '0, '1, 1'b0);
    MEM_READ = 1'b1; MEM_WRITE = 1'b1; MEM_ADDRESS = 28'd3; DATA_IN = '0;
    exp_busy = 1'b0;
    repeat (3) step();
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    step();
    access(1'b1, 1'b0, 28'd3, '0, '1, 1'b0);
    check("rd3_after_both", DATA_OUT, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    access(1'b0, 1'b1, 28'd2, D2, '1, 1'b1);
    access(1'b1, 1'b0, 28'd2, '0, '1, 1'b0);
    check("rd2_latched", DATA_OUT, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
    access(1'b1, 1'b0, 28'd4, '0, '1, 1'b0);
    check("rd4_untouched", DATA_OUT, 128'h0);

`ifdef DMEM_WRITE_MASK_EN
    access(1'b0, 1'b1, 28'd0, {128{1'b1}}, 16'hFFFF, 1'b0);
    access(1'b0, 1'b1, 28'd0, 128'h0, 16'h000F, 1'b0);
    access(1'b1, 1'b0, 28'd0, '0, '1, 1'b0);
    check("rd0_masked", DATA_OUT, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
    access(1'b0, 1'b1, 28'd0, 128'h0, 16'h0000, 1'b0);
    access(1'b1, 1'b0, 28'd0, '0, '1, 1'b0);
    check("rd0_zero_mask", DATA_OUT, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000);
`endif

    // Reset two cycles into a write to block 9
    MEM_WRITE = 1'b1; MEM_ADDRESS = 28'd9; DATA_IN = D3;
    exp_busy = 1'b1;
    repeat (3) step();
    do_reset();
    access(1'b1, 1'b0, 28'd9, '0, '1, 1'b0);
    check("rd9_after_abort", DATA_OUT, 128'h0);
    access(1'b1, 1'b0, 28'd3, '0, '1, 1'b0);
    check("rd3_cleared", DATA_OUT, 128'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
